bcd_counter_n: RTL and testbench

Parametrised multi-digit synchronous BCD counter. It is the successor to the single-digit BCD stage and feeds the seven-segment display multiplexer and the timer logic. It adds:
- configurable digit count
- up/down mode
- count enable
- parallel load with BCD sanitising
- a combinational terminal-count flag and a registered wrap pulse for cascading.

---
 rtl/bcd_counter_n.sv | 72 +++++++
 tb/tb_bcd_counter_n.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD counter, falling-edge clocked.
// Supports up/down counting, count enable and parallel load with per-nibble
// clamping to 9. Provides a combinational terminal-count flag and a registered
// one-cycle wrap pulse for cascading.
module bcd_counter_n #(
  parameter int                  DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap
);

  // Clamp every nibble of a BCD word to 0..9.
  function automatic logic [4*DIGITS-1:0] sanitise(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Step a single BCD digit by one in the requested direction, wrapping 9<->0.
  function automatic logic [3:0] step_digit(input logic [3:0] d, input logic up);
    logic [3:0] r;
    if (up) r = (d >= 4'd9) ? 4'd0 : d + 4'd1;
    else    r = (d == 4'd0) ? 4'd9 : d - 4'd1;
    return r;
  endfunction

  logic [4*DIGITS-1:0] count_nxt;
  logic                at_end;

  // Combinational per-digit carry/borrow chain; at_end means every digit is at
  // its terminal value (9 going up, 0 going down).
  always_comb begin
    logic carry;
    count_nxt = count;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) count_nxt[4*i +: 4] = step_digit(count[4*i +: 4], up_dn);
      carry = carry & (up_dn ? (count[4*i +: 4] == 4'd9) : (count[4*i +: 4] == 4'd0));
    end
    at_end = carry;
  end

  assign tc = en & at_end;

  // State update: reset > load > en, otherwise hold; wrap pulses after a wrap.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      count <= sanitise(RESET_VAL);
      wrap  <= 1'b0;
    end else if (load) begin
      count <= sanitise(load_val);
      wrap  <= 1'b0;
    end else if (en) begin
      count <= count_nxt;
      wrap  <= at_end;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n: directed cases, randomized traffic
// against an integer reference model, and a two-instance cascade.
module tb_bcd_counter_n;

  localparam int MOD  = 10000;
  localparam int MAXV = MOD - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count;
  logic        tc, wrap;

  logic        c_en = 1'b0, c_up = 1'b1, c_load = 1'b0;
  logic [15:0] c_lo_val = '0, c_hi_val = '0;
  logic [15:0] lo_count, hi_count;
  logic        lo_tc, lo_wrap, hi_tc, hi_wrap;

  int n_cmp = 0;
  int n_bad = 0;
  int m_val = 0;
  bit m_wrap = 1'b0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
  );

  bcd_counter_n #(.DIGITS(4)) lo (
    .clk(clk), .reset(reset), .en(c_en), .up_dn(c_up), .load(c_load),
    .load_val(c_lo_val), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap)
  );

  bcd_counter_n #(.DIGITS(4)) hi (
    .clk(clk), .reset(reset), .en(lo_tc), .up_dn(c_up), .load(c_load),
    .load_val(c_hi_val), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [15:0] lv);
    int s, p, nib;
    s = 0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      nib = int'(lv[4*i +: 4]);
      if (nib > 9) nib = 9;
      s = s + nib * p;
      p = p * 10;
    end
    return s;
  endfunction

  function automatic bit model_tc();
    return en && (up_dn ? (m_val == MAXV) : (m_val == 0));
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_val = 0; m_wrap = 1'b0;
    end else if (load) begin
      m_val = load_value(load_val); m_wrap = 1'b0;
    end else if (en) begin
      if (up_dn) begin
        m_wrap = (m_val == MAXV);
        m_val  = (m_val + 1) % MOD;
      end else begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + MOD - 1) % MOD;
      end
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  // One active (falling) edge, then check at the following rising edge.
  task automatic tick();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    chk("count", 32'(count), 32'(to_bcd(m_val)));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("tc", 32'(tc), 32'(model_tc()));
  endtask

  task automatic drive(input logic l, input logic e, input logic u, input logic [15:0] lv);
    load = l; en = e; up_dn = u; load_val = lv;
  endtask

  initial begin
    // 1: asynchronous reset mid-cycle, then hold with en=0
    #2 reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_tc", 32'(tc), 32'h0);
    @(posedge clk);
    reset = 1'b1;
    m_val = 0; m_wrap = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // 2: decimal carry across digits
    drive(1'b1, 1'b0, 1'b1, 16'h0998); tick();
    drive(1'b0, 1'b1, 1'b1, 16'h0000);
    tick(); chk("t2_a", 32'(count), 32'h0999);
    tick(); chk("t2_b", 32'(count), 32'h1000);
    tick(); chk("t2_c", 32'(count), 32'h1001);

    // 3: wrap going up
    drive(1'b1, 1'b0, 1'b1, 16'h9998); tick();
    drive(1'b0, 1'b1, 1'b1, 16'h0000);
    tick(); chk("t3_tc", 32'(tc), 32'h1);
    tick(); chk("t3_wrap", 32'(wrap), 32'h1); chk("t3_cnt0", 32'(count), 32'h0);
    tick(); chk("t3_wrap_off", 32'(wrap), 32'h0);

    // 4: wrap going down, then direction flip at all-nines
    drive(1'b1, 1'b0, 1'b0, 16'h0001); tick();
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    tick(); chk("t4_tc0", 32'(tc), 32'h1);
    tick(); chk("t4_cnt9", 32'(count), 32'h9999); chk("t4_wrap", 32'(wrap), 32'h1);
    drive(1'b0, 1'b1, 1'b1, 16'h0000);
    #1 chk("t4_tc_flip", 32'(tc), 32'(model_tc()));
    tick(); chk("t4_wrap_up", 32'(wrap), 32'h1);

    // 5: load sanitising and load priority over en
    drive(1'b1, 1'b0, 1'b1, 16'hA3F5); tick(); chk("t5_sanit", 32'(count), 32'h9395);
    drive(1'b1, 1'b1, 1'b1, 16'h1234); tick(); chk("t5_prio", 32'(count), 32'h1234);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), 16'($urandom));
      if ($urandom_range(0, 29) == 0) begin
        #2 reset = 1'b0;
        m_val = 0; m_wrap = 1'b0;
        #1 chk("rnd_async_rst", 32'(count), 32'h0);
        #1 reset = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        // force edge-of-range values to exercise wrap often
        drive(1'b1, 1'b0, 1'b1, ($urandom_range(0, 1) != 0) ? 16'h9999 : 16'h0000);
      end
      tick();
    end

    // 6: cascade, upper en driven by lower tc
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    c_load = 1'b1; c_lo_val = 16'h9999; c_hi_val = 16'h0123;
    @(negedge clk); @(posedge clk);
    c_load = 1'b0;
    chk("c_lo_load", 32'(lo_count), 32'h9999);
    chk("c_hi_load", 32'(hi_count), 32'h0123);
    chk("c_tc_off", 32'(lo_tc), 32'h0);
    c_en = 1'b1; c_up = 1'b1;
    #1 chk("c_tc_on", 32'(lo_tc), 32'h1);
    @(negedge clk); @(posedge clk);
    chk("c_lo_wrap", 32'(lo_count), 32'h0000);
    chk("c_hi_inc", 32'(hi_count), 32'h0124);
    chk("c_lo_wrap_p", 32'(lo_wrap), 32'h1);
    @(negedge clk); @(posedge clk);
    chk("c_lo_next", 32'(lo_count), 32'h0001);
    chk("c_hi_hold", 32'(hi_count), 32'h0124);
    #2 reset = 1'b0;
    #1;
    chk("c_lo_rst", 32'(lo_count), 32'h0);
    chk("c_hi_rst", 32'(hi_count), 32'h0);
    chk("c_lo_wrap_rst", 32'(lo_wrap), 32'h0);
    #1 reset = 1'b1;
    c_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
